// File: rtl/scan_buffer_ctrl_if.sv
// Control/strobe bundle between the scanner datapath and scan_buffer_ctrl.
// master drives the requests; slave (the controller) drives the buffer strobes and status.
interface scan_buffer_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start_scan;
    logic             sample_valid;
    logic             xfer_req;
    logic             abort;
    logic             scanning_a;
    logic             scanning_b;
    logic             transfer_a;
    logic             transfer_b;
    logic             flush_a;
    logic             flush_b;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             xfer_sel;
    logic             full_a;
    logic             full_b;
    logic             frame_done;
    logic             xfer_done;
    logic             overflow;
    logic             busy;

    modport master (
        output start_scan, sample_valid, xfer_req, abort,
        input  scanning_a, scanning_b, transfer_a, transfer_b, flush_a, flush_b,
        input  wr_cnt, rd_cnt, xfer_sel, full_a, full_b, frame_done, xfer_done,
        input  overflow, busy
    );

    modport slave (
        input  start_scan, sample_valid, xfer_req, abort,
        output scanning_a, scanning_b, transfer_a, transfer_b, flush_a, flush_b,
        output wr_cnt, rd_cnt, xfer_sel, full_a, full_b, frame_done, xfer_done,
        output overflow, busy
    );
endinterface

// File: rtl/scan_buffer_ctrl.sv
// Ping-pong sequencer for two DEPTH-byte scanner frame buffers: one fills while the other drains.
// Latency: every output registered, one cycle after its trigger; no backpressure, a drain runs DEPTH cycles then flushes.
module scan_buffer_ctrl #(
    parameter int DEPTH = 10,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    scan_buffer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} buf_st_t;
    typedef enum logic       {S_IDLE, S_SCAN} scan_st_t;
    typedef enum logic [1:0] {T_IDLE, T_XFER, T_FLUSH} xfer_st_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    scan_st_t         r_scan_st, w_scan_nxt;
    xfer_st_t         r_xfer_st, w_xfer_nxt;
    buf_st_t          r_bst [2];
    buf_st_t          w_bst_nxt [2];
    logic             r_scan_sel, w_scan_sel_nxt;
    logic             r_xfer_sel, w_xfer_sel_nxt;
    logic [CNT_W-1:0] r_wr_cnt, w_wr_nxt;
    logic [CNT_W-1:0] r_rd_cnt, w_rd_nxt;
    logic             r_order, w_order_nxt;
    logic             r_overflow, w_ovf_nxt;
    logic             w_frame_done_nxt, w_xfer_done_nxt;
    logic             w_pick;

    logic r_scanning_a, r_scanning_b, r_transfer_a, r_transfer_b;
    logic r_flush_a, r_flush_b, r_full_a, r_full_b;
    logic r_frame_done, r_xfer_done, r_busy;
    logic w_scanning_a, w_scanning_b, w_transfer_a, w_transfer_b;
    logic w_flush_a, w_flush_b, w_full_a, w_full_b, w_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_st    <= S_IDLE;
            r_xfer_st    <= T_IDLE;
            r_bst[0]     <= B_EMPTY;
            r_bst[1]     <= B_EMPTY;
            r_scan_sel   <= 1'b0;
            r_xfer_sel   <= 1'b0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_order      <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
            r_xfer_done  <= 1'b0;
            r_scanning_a <= 1'b0;
            r_scanning_b <= 1'b0;
            r_transfer_a <= 1'b0;
            r_transfer_b <= 1'b0;
            r_flush_a    <= 1'b0;
            r_flush_b    <= 1'b0;
            r_full_a     <= 1'b0;
            r_full_b     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_scan_st    <= w_scan_nxt;
            r_xfer_st    <= w_xfer_nxt;
            r_bst[0]     <= w_bst_nxt[0];
            r_bst[1]     <= w_bst_nxt[1];
            r_scan_sel   <= w_scan_sel_nxt;
            r_xfer_sel   <= w_xfer_sel_nxt;
            r_wr_cnt     <= w_wr_nxt;
            r_rd_cnt     <= w_rd_nxt;
            r_order      <= w_order_nxt;
            r_overflow   <= w_ovf_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_xfer_done  <= w_xfer_done_nxt;
            r_scanning_a <= w_scanning_a;
            r_scanning_b <= w_scanning_b;
            r_transfer_a <= w_transfer_a;
            r_transfer_b <= w_transfer_b;
            r_flush_a    <= w_flush_a;
            r_flush_b    <= w_flush_b;
            r_full_a     <= w_full_a;
            r_full_b     <= w_full_b;
            r_busy       <= w_busy;
        end
    end

    // Older FULL buffer wins when both hold a frame; r_order names the older one.
    always_comb begin
        if (r_bst[0] == B_FULL && r_bst[1] == B_FULL) begin
            w_pick = r_order;
        end else begin
            w_pick = (r_bst[1] == B_FULL);
        end
    end

    always_comb begin
        w_scan_nxt       = r_scan_st;
        w_xfer_nxt       = r_xfer_st;
        w_bst_nxt[0]     = r_bst[0];
        w_bst_nxt[1]     = r_bst[1];
        w_scan_sel_nxt   = r_scan_sel;
        w_xfer_sel_nxt   = r_xfer_sel;
        w_wr_nxt         = r_wr_cnt;
        w_rd_nxt         = r_rd_cnt;
        w_order_nxt      = r_order;
        w_ovf_nxt        = r_overflow;
        w_frame_done_nxt = 1'b0;
        w_xfer_done_nxt  = 1'b0;
        if (bus.abort) begin
            w_scan_nxt   = S_IDLE;
            w_xfer_nxt   = T_IDLE;
            w_bst_nxt[0] = B_EMPTY;
            w_bst_nxt[1] = B_EMPTY;
            w_wr_nxt     = '0;
            w_rd_nxt     = '0;
            w_ovf_nxt    = 1'b0;
        end else begin
            unique case (r_scan_st)
                S_IDLE: begin
                    if (bus.start_scan) begin
                        if (r_bst[0] == B_EMPTY || r_bst[1] == B_EMPTY) begin
                            w_scan_sel_nxt            = (r_bst[0] != B_EMPTY);
                            w_bst_nxt[w_scan_sel_nxt] = B_FILLING;
                            w_wr_nxt                  = '0;
                            w_scan_nxt                = S_SCAN;
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (bus.sample_valid) begin
                        if (r_wr_cnt == LAST) begin
                            w_bst_nxt[r_scan_sel] = B_FULL;
                            w_wr_nxt              = '0;
                            w_frame_done_nxt      = 1'b1;
                            w_scan_nxt            = S_IDLE;
                        end else begin
                            w_wr_nxt = r_wr_cnt + CNT_W'(1);
                        end
                    end
                end
                default: w_scan_nxt = S_IDLE;
            endcase

            unique case (r_xfer_st)
                T_IDLE: begin
                    if (bus.xfer_req && (r_bst[0] == B_FULL || r_bst[1] == B_FULL)) begin
                        w_xfer_sel_nxt    = w_pick;
                        w_bst_nxt[w_pick] = B_DRAINING;
                        w_rd_nxt          = '0;
                        w_xfer_nxt        = T_XFER;
                    end
                end
                T_XFER: begin
                    if (r_rd_cnt == LAST) begin
                        w_rd_nxt        = '0;
                        w_xfer_done_nxt = 1'b1;
                        w_xfer_nxt      = T_FLUSH;
                    end else begin
                        w_rd_nxt = r_rd_cnt + CNT_W'(1);
                    end
                end
                T_FLUSH: begin
                    w_bst_nxt[r_xfer_sel] = B_EMPTY;
                    w_xfer_nxt            = T_IDLE;
                end
                default: w_xfer_nxt = T_IDLE;
            endcase

            // The drain decision above already saw the other buffer, so its next state is final here.
            if (w_frame_done_nxt) begin
                w_order_nxt = (w_bst_nxt[~r_scan_sel] == B_FULL) ? ~r_scan_sel : r_scan_sel;
            end
        end
    end

    always_comb begin
        w_scanning_a = (w_scan_nxt == S_SCAN) && !w_scan_sel_nxt;
        w_scanning_b = (w_scan_nxt == S_SCAN) &&  w_scan_sel_nxt;
        w_transfer_a = (w_xfer_nxt == T_XFER) && !w_xfer_sel_nxt;
        w_transfer_b = (w_xfer_nxt == T_XFER) &&  w_xfer_sel_nxt;
        w_flush_a    = bus.abort || ((w_xfer_nxt == T_FLUSH) && !w_xfer_sel_nxt);
        w_flush_b    = bus.abort || ((w_xfer_nxt == T_FLUSH) &&  w_xfer_sel_nxt);
        w_full_a     = (w_bst_nxt[0] == B_FULL);
        w_full_b     = (w_bst_nxt[1] == B_FULL);
        w_busy       = (w_scan_nxt != S_IDLE) || (w_xfer_nxt != T_IDLE);
    end

    assign bus.scanning_a = r_scanning_a;
    assign bus.scanning_b = r_scanning_b;
    assign bus.transfer_a = r_transfer_a;
    assign bus.transfer_b = r_transfer_b;
    assign bus.flush_a    = r_flush_a;
    assign bus.flush_b    = r_flush_b;
    assign bus.wr_cnt     = r_wr_cnt;
    assign bus.rd_cnt     = r_rd_cnt;
    assign bus.xfer_sel   = r_xfer_sel;
    assign bus.full_a     = r_full_a;
    assign bus.full_b     = r_full_b;
    assign bus.frame_done = r_frame_done;
    assign bus.xfer_done  = r_xfer_done;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = r_busy;
endmodule
